// File: rtl/dvp_frame_wr_sched.sv
// Schedules AXI4 write bursts from the DVP line FIFO into a rotating set of DDR frame buffers,
// skipping the buffer held by the reader and publishing the last cleanly written buffer.
module dvp_frame_wr_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 8,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BUFS   = 3,
    parameter int MAX_OUTST  = 4,
    parameter int CNT_W      = 12
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [31:0]       cfg_frame_bytes,
    input  logic              frame_start,
    input  logic [CNT_W-1:0]  fifo_words,
    input  logic              w_beat,
    input  logic [1:0]        rd_buf_idx,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              bresp_valid,
    input  logic [1:0]        bresp,
    output logic [1:0]        wr_buf_idx,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int LOG_DB = $clog2(DATA_BYTES);
    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int PEND_W = CNT_W + 1;
    localparam int NEED_W = CNT_W + 10;

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ISSUE, DRAIN, COMMIT} state_t;
    state_t state_q, state_d;

    logic [1:0]        cur_idx, nxt_idx, wr_idx_q;
    logic [ADDR_W-1:0] addr_q, cmd_addr_q;
    logic [31:0]       rem_q;
    logic [OUT_W-1:0]  outst_q;
    logic [PEND_W-1:0] pending_q;
    logic              abort_q, err_q;
    logic              cmd_valid_q;
    logic [7:0]        cmd_len_q;

    logic [1:0]        sof_try, sof_idx;
    logic [31:0]       sof_rem, beats_w;
    logic [12:0]       to_4k;
    logic [8:0]        beats, beats_q;
    logic              hs, fs_abort, launch, sof_take;

    function automatic logic [1:0] idx_inc(input logic [1:0] i);
        return (32'(i) >= NUM_BUFS - 1) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        sof_try  = idx_inc(cur_idx);
        sof_idx  = (sof_try == rd_buf_idx) ? idx_inc(sof_try) : sof_try;
        sof_rem  = cfg_frame_bytes >> LOG_DB;
        sof_take = (state_q == WAIT_SOF) && cfg_enable && frame_start;
        // Beats left before the next 4 KB boundary caps every burst.
        to_4k    = (13'd4096 - {1'b0, addr_q[11:0]}) >> LOG_DB;
        beats_w  = 32'(BURST_LEN);
        if (rem_q < beats_w)
            beats_w = rem_q;
        if (32'(to_4k) < beats_w)
            beats_w = 32'(to_4k);
        beats    = 9'(beats_w);
        beats_q  = {1'b0, cmd_len_q} + 9'd1;
        hs       = cmd_valid_q && cmd_ready;
        fs_abort = (state_q == ISSUE) && frame_start && (rem_q != '0);
        launch   = (state_q == ISSUE) && !cmd_valid_q && (rem_q != '0)
                   && !abort_q && !fs_abort
                   && (32'(outst_q) < MAX_OUTST)
                   && (NEED_W'(fifo_words) >= NEED_W'(pending_q) + NEED_W'(beats));
    end

    always_ff @(posedge ACLK) begin
        if (ARESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cfg_enable) state_d = WAIT_SOF;
            WAIT_SOF: begin
                if (!cfg_enable)
                    state_d = IDLE;
                else if (frame_start)
                    state_d = (sof_rem == '0) ? DRAIN : ISSUE;
            end
            ISSUE: begin
                // An overrun still lets a presented command finish its handshake.
                if ((abort_q || fs_abort) && (!cmd_valid_q || cmd_ready))
                    state_d = DRAIN;
                else if ((rem_q == '0) && !cmd_valid_q)
                    state_d = DRAIN;
            end
            DRAIN:    if (outst_q == '0) state_d = COMMIT;
            COMMIT:   state_d = cfg_enable ? WAIT_SOF : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        frame_done = (state_q == COMMIT) && !abort_q && !err_q;
        frame_err  = (state_q == COMMIT) && (abort_q || err_q);
        cmd_valid  = cmd_valid_q;
        cmd_addr   = cmd_addr_q;
        cmd_len    = cmd_len_q;
        wr_buf_idx = wr_idx_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cur_idx     <= 2'(NUM_BUFS - 1);
            nxt_idx     <= '0;
            wr_idx_q    <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            outst_q     <= '0;
            pending_q   <= '0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
        end else begin
            if (sof_take) begin
                nxt_idx <= sof_idx;
                addr_q  <= cfg_base_addr + ADDR_W'(sof_idx) * cfg_stride;
                rem_q   <= sof_rem;
            end
            if (launch) begin
                cmd_valid_q <= 1'b1;
                cmd_addr_q  <= addr_q;
                cmd_len_q   <= 8'(beats - 9'd1);
            end
            if (hs) begin
                cmd_valid_q <= 1'b0;
                addr_q      <= addr_q + (ADDR_W'(beats_q) << LOG_DB);
                rem_q       <= rem_q - 32'(beats_q);
            end
            case ({hs, bresp_valid})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
            pending_q <= pending_q + (hs ? PEND_W'(beats_q) : '0) - PEND_W'(w_beat);
            if (fs_abort)
                abort_q <= 1'b1;
            if (bresp_valid && (bresp != 2'b00))
                err_q <= 1'b1;
            if (state_q == COMMIT) begin
                if (!abort_q && !err_q) begin
                    cur_idx  <= nxt_idx;
                    wr_idx_q <= nxt_idx;
                end
                abort_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end
endmodule
